// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction-ROM addressing, branch-LUT resolution and IDLE/RUN/HALT sequencer.
// Build option FETCH_ABS_BRANCH_EN: LUT entries are absolute targets; otherwise signed PC-relative offsets.
module fetch_unit #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 9,
    parameter int                 OP_W       = 3,
    parameter int                 LUT_DEPTH  = 8,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
    parameter int                 CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               Branch,
    input  logic               Taken,
    input  logic [2:0]         HowHigh,
    input  logic               LutWe,
    input  logic [2:0]         LutAddr,
    input  logic [PC_W-1:0]    LutData,
    output logic [PC_W-1:0]    PC,
    output logic [OP_W-1:0]    ALUOp,
    output logic               Valid,
    output logic               Done,
    output logic [CNT_W-1:0]   CycleCnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];
    logic [PC_W-1:0]   lut_d [LUT_DEPTH];

    logic              is_halt_s;
    logic              br_taken_s;
    logic              lut_wr_en_s;
    logic [PC_W-1:0]   lut_rd_s;
    logic [PC_W-1:0]   br_target_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign is_halt_s   = (Instr == HALT_INSTR);
    assign br_taken_s  = Branch && Taken;
    // The table is frozen while a program runs so branch targets cannot change under it.
    assign lut_wr_en_s = LutWe && (state_q != ST_RUN);
    assign lut_rd_s    = lut_q[HowHigh];

`ifdef FETCH_ABS_BRANCH_EN
    assign br_target_s = lut_rd_s;
`else
    assign br_target_s = pc_q + lut_rd_s;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (is_halt_s) state_d = ST_HALT;
                else           state_d = ST_RUN;
            end
            ST_HALT: begin
                if (Start) state_d = ST_RUN;
                else       state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; a halt instruction outranks a taken branch.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    pc_d  = {PC_W{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    pc_d  = pc_q;
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (is_halt_s) begin
                    pc_d = pc_q;
                end else if (br_taken_s) begin
                    pc_d = br_target_s;
                end else begin
                    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                pc_d  = {PC_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
        done_d  = (state_d == ST_HALT);
        valid_d = (state_d == ST_RUN);
    end

    // Branch-target table write port.
    always_comb begin
        lut_d = lut_q;
        if (lut_wr_en_s) begin
            lut_d[LutAddr] = LutData;
        end else begin
            lut_d = lut_q;
        end
    end

    // Datapath and table registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= {PC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= {PC_W{1'b0}};
            end
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            lut_q   <= lut_d;
        end
    end

    assign PC       = pc_q;
    assign ALUOp    = Instr[INSTR_W-1 -: OP_W];
    assign Valid    = valid_q;
    assign Done     = done_q;
    assign CycleCnt = cnt_q;

endmodule
